// File: rtl/cache_arbiter_pkg.sv
// Shared types for the instruction/data cache memory-port arbiter.
package rv32i_types;

  // Arbiter control states
  typedef enum logic [1:0] {
    IDLE,
    I_BUSY,
    D_BUSY,
    RELEASE
  } arb_state_t;

  // Identity of the cache that owns (or last owned) the memory port
  typedef enum logic {
    ARB_I,
    ARB_D
  } arb_owner_t;

endpackage

// File: rtl/cache_arbiter_pick.sv
// Combinational owner selection from the two pending request bits.
// Tie rule set by CACHE_ARB_ROUND_ROBIN_EN:
//   defined   -> alternate away from last_grant
//   undefined -> D-cache always wins a tie
module cache_arbiter_pick
  import rv32i_types::*;
(
  input  logic       pend_i,
  input  logic       pend_d,
  input  arb_owner_t last_grant,
  output logic       grant_valid,
  output arb_owner_t grant_owner
);

`ifndef CACHE_ARB_ROUND_ROBIN_EN
  // Fixed priority keeps last_grant as history only
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;
`endif

  // Pick a single owner; a lone requester always wins
  always_comb begin
    grant_valid = pend_i | pend_d;
    grant_owner = ARB_I;
    if (pend_i && pend_d) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      grant_owner = (last_grant == ARB_I) ? ARB_D : ARB_I;
`else
      grant_owner = ARB_D;
`endif
    end else if (pend_d) begin
      grant_owner = ARB_D;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Single physical-memory port shared between I-cache and D-cache.
// One line transfer at a time; request registered toward memory,
// response routed combinationally to the owner only.
// Optional feature macro: CACHE_ARB_ROUND_ROBIN_EN (tie rule in cache_arbiter_pick).
module cache_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              icache_pmem_read,
  input  logic [ADDR_W-1:0] icache_pmem_address,
  output logic [LINE_W-1:0] icache_pmem_rdata,
  output logic              icache_pmem_resp,

  input  logic              dcache_pmem_read,
  input  logic              dcache_pmem_write,
  input  logic [ADDR_W-1:0] dcache_pmem_address,
  input  logic [LINE_W-1:0] dcache_pmem_wdata,
  output logic [LINE_W-1:0] dcache_pmem_rdata,
  output logic              dcache_pmem_resp,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t state_q, state_d;
  arb_owner_t last_grant_q, last_grant_d;
  arb_owner_t grant_owner;
  logic       grant_valid;
  logic       grant_load;
  logic       xfer_done;

  cache_arbiter_pick u_pick (
    .pend_i      (icache_pmem_read),
    .pend_d      (dcache_pmem_read | dcache_pmem_write),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  // Read data is broadcast; only the owner's resp qualifies it
  assign icache_pmem_rdata = pmem_rdata;
  assign dcache_pmem_rdata = pmem_rdata;

  // State and grant-history register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= ARB_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state, grant strobe and owner response routing
  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    grant_load       = 1'b0;
    xfer_done        = 1'b0;
    icache_pmem_resp = 1'b0;
    dcache_pmem_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          grant_load   = 1'b1;
          last_grant_d = grant_owner;
          state_d      = (grant_owner == ARB_I) ? I_BUSY : D_BUSY;
        end
      end
      I_BUSY: begin
        icache_pmem_resp = pmem_resp;
        if (pmem_resp) begin
          xfer_done = 1'b1;
          state_d   = RELEASE;
        end
      end
      D_BUSY: begin
        dcache_pmem_resp = pmem_resp;
        if (pmem_resp) begin
          xfer_done = 1'b1;
          state_d   = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory-side request registers; frozen for the whole transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else if (grant_load) begin
      if (grant_owner == ARB_I) begin
        pmem_read    <= 1'b1;
        pmem_write   <= 1'b0;
        pmem_address <= icache_pmem_address;
        pmem_wdata   <= '0;
      end else begin
        // read+write together is illegal; write-back takes precedence
        pmem_read    <= dcache_pmem_read & ~dcache_pmem_write;
        pmem_write   <= dcache_pmem_write;
        pmem_address <= dcache_pmem_address;
        pmem_wdata   <= dcache_pmem_wdata;
      end
    end else if (xfer_done) begin
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter.
module tb_cache_arbiter;
  import rv32i_types::*;

  logic         clk;
  logic         rst_n;
  logic         icache_pmem_read;
  logic [31:0]  icache_pmem_address;
  logic [255:0] icache_pmem_rdata;
  logic         icache_pmem_resp;
  logic         dcache_pmem_read;
  logic         dcache_pmem_write;
  logic [31:0]  dcache_pmem_address;
  logic [255:0] dcache_pmem_wdata;
  logic [255:0] dcache_pmem_rdata;
  logic         dcache_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  int vecs = 0;
  int errs = 0;

  cache_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .icache_pmem_read    (icache_pmem_read),
    .icache_pmem_address (icache_pmem_address),
    .icache_pmem_rdata   (icache_pmem_rdata),
    .icache_pmem_resp    (icache_pmem_resp),
    .dcache_pmem_read    (dcache_pmem_read),
    .dcache_pmem_write   (dcache_pmem_write),
    .dcache_pmem_address (dcache_pmem_address),
    .dcache_pmem_wdata   (dcache_pmem_wdata),
    .dcache_pmem_rdata   (dcache_pmem_rdata),
    .dcache_pmem_resp    (dcache_pmem_resp),
    .pmem_read           (pmem_read),
    .pmem_write          (pmem_write),
    .pmem_address        (pmem_address),
    .pmem_wdata          (pmem_wdata),
    .pmem_rdata          (pmem_rdata),
    .pmem_resp           (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then return at the following falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  localparam logic [255:0] PAT_R  = {8{32'hDEADBEEF}};
  localparam logic [255:0] PAT_A5 = {32{8'hA5}};
  localparam logic [255:0] PAT_W2 = {8{32'h1234_5678}};

  initial begin
    rst_n = 1'b0;
    icache_pmem_read = 1'b0;  icache_pmem_address = '0;
    dcache_pmem_read = 1'b0;  dcache_pmem_write = 1'b0;
    dcache_pmem_address = '0; dcache_pmem_wdata = '0;
    pmem_rdata = '0;          pmem_resp = 1'b0;

    // Reset values
    #12;
    chk("rst_pmem_read",    pmem_read,        '0);
    chk("rst_pmem_write",   pmem_write,       '0);
    chk("rst_pmem_address", pmem_address,     '0);
    chk("rst_pmem_wdata",   pmem_wdata,       '0);
    chk("rst_iresp",        icache_pmem_resp, '0);
    chk("rst_dresp",        dcache_pmem_resp, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // I-only read; address change mid-transfer must not leak through
    icache_pmem_read = 1'b1; icache_pmem_address = 32'h0000_1000;
    tick();
    chk("i_read_hi",   pmem_read,    1'b1);
    chk("i_write_lo",  pmem_write,   1'b0);
    chk("i_addr",      pmem_address, 32'h0000_1000);
    icache_pmem_address = 32'h0000_3000;
    tick();
    chk("i_addr_hold", pmem_address, 32'h0000_1000);
    tick();
    chk("i_read_hold", pmem_read,    1'b1);
    tick();
    chk("i_addr_hold2", pmem_address, 32'h0000_1000);
    pmem_resp = 1'b1; pmem_rdata = PAT_R;
    #1;
    chk("i_iresp",  icache_pmem_resp,  1'b1);
    chk("i_dresp",  dcache_pmem_resp,  1'b0);
    chk("i_rdata",  icache_pmem_rdata, PAT_R);
    tick();
    pmem_resp = 1'b0; icache_pmem_read = 1'b0;
    chk("i_read_clr", pmem_read, 1'b0);
    chk("i_iresp_pulse", icache_pmem_resp, 1'b0);
    tick();

    // Spurious memory response while idle
    pmem_resp = 1'b1;
    #1;
    chk("spur_iresp", icache_pmem_resp, 1'b0);
    chk("spur_dresp", dcache_pmem_resp, 1'b0);
    tick();
    pmem_resp = 1'b0;
    chk("spur_state", dut.state_q, IDLE);
    chk("spur_read",  pmem_read,  1'b0);
    chk("spur_write", pmem_write, 1'b0);

    // Simultaneous I and D reads straight after reset: D first
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    icache_pmem_read = 1'b1; icache_pmem_address = 32'h0000_1000;
    dcache_pmem_read = 1'b1; dcache_pmem_address = 32'h0000_5000;
    tick();
    chk("tie1_addr", pmem_address, 32'h0000_5000);
    chk("tie1_read", pmem_read,    1'b1);
    tick();
    pmem_resp = 1'b1;
    #1;
    chk("tie1_dresp", dcache_pmem_resp, 1'b1);
    chk("tie1_iresp", icache_pmem_resp, 1'b0);
    tick();
    pmem_resp = 1'b0; dcache_pmem_read = 1'b0;
    chk("tie1_release_read", pmem_read, 1'b0);
    tick();
    chk("tie1_dead_read", pmem_read, 1'b0);
    tick();
    chk("tie1_i_read", pmem_read,    1'b1);
    chk("tie1_i_addr", pmem_address, 32'h0000_1000);
    pmem_resp = 1'b1;
    #1;
    chk("tie1_i_iresp", icache_pmem_resp, 1'b1);
    chk("tie1_i_dresp", dcache_pmem_resp, 1'b0);
    tick();
    pmem_resp = 1'b0; icache_pmem_read = 1'b0;
    tick();

    // D write-back
    dcache_pmem_write = 1'b1; dcache_pmem_address = 32'h0000_2040;
    dcache_pmem_wdata = PAT_A5;
    tick();
    chk("wb_write", pmem_write,   1'b1);
    chk("wb_read",  pmem_read,    1'b0);
    chk("wb_addr",  pmem_address, 32'h0000_2040);
    chk("wb_wdata", pmem_wdata,   PAT_A5);
    tick();
    chk("wb_read2", pmem_read, 1'b0);
    pmem_resp = 1'b1;
    #1;
    chk("wb_dresp", dcache_pmem_resp, 1'b1);
    chk("wb_iresp", icache_pmem_resp, 1'b0);
    chk("wb_read3", pmem_read, 1'b0);
    tick();
    pmem_resp = 1'b0; dcache_pmem_write = 1'b0;
    chk("wb_write_clr", pmem_write, 1'b0);
    tick();

    // Second simultaneous pair; last grant was D
    icache_pmem_read = 1'b1; icache_pmem_address = 32'h0000_1100;
    dcache_pmem_read = 1'b1; dcache_pmem_address = 32'h0000_5100;
    tick();
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    chk("tie2_first", pmem_address, 32'h0000_1100);
    pmem_resp = 1'b1;
    #1;
    chk("tie2_first_resp", icache_pmem_resp, 1'b1);
    tick();
    pmem_resp = 1'b0; icache_pmem_read = 1'b0;
    tick();
    tick();
    chk("tie2_second", pmem_address, 32'h0000_5100);
    pmem_resp = 1'b1;
    #1;
    chk("tie2_second_resp", dcache_pmem_resp, 1'b1);
`else
    chk("tie2_first", pmem_address, 32'h0000_5100);
    pmem_resp = 1'b1;
    #1;
    chk("tie2_first_resp", dcache_pmem_resp, 1'b1);
    tick();
    pmem_resp = 1'b0; dcache_pmem_read = 1'b0;
    tick();
    tick();
    chk("tie2_second", pmem_address, 32'h0000_1100);
    pmem_resp = 1'b1;
    #1;
    chk("tie2_second_resp", icache_pmem_resp, 1'b1);
`endif
    tick();
    pmem_resp = 1'b0; icache_pmem_read = 1'b0; dcache_pmem_read = 1'b0;
    tick();

    // Illegal read+write issues a write; then reset mid-transfer
    dcache_pmem_read = 1'b1; dcache_pmem_write = 1'b1;
    dcache_pmem_address = 32'h0000_6000; dcache_pmem_wdata = PAT_W2;
    tick();
    chk("rw_write", pmem_write, 1'b1);
    chk("rw_read",  pmem_read,  1'b0);
    chk("rw_wdata", pmem_wdata, PAT_W2);
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_write", pmem_write,   1'b0);
    chk("arst_read",  pmem_read,    1'b0);
    chk("arst_addr",  pmem_address, '0);
    chk("arst_wdata", pmem_wdata,   '0);
    dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0;
    tick();
    rst_n = 1'b1;
    icache_pmem_read = 1'b1; icache_pmem_address = 32'h0000_7000;
    tick();
    chk("post_rst_read", pmem_read,    1'b1);
    chk("post_rst_addr", pmem_address, 32'h0000_7000);
    pmem_resp = 1'b1;
    #1;
    chk("post_rst_iresp", icache_pmem_resp, 1'b1);
    tick();
    pmem_resp = 1'b0; icache_pmem_read = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
